pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the multi-cycle/pipelined CPU datapath; successor to the fixed 32-bit PC register. Holds the fetch address, computes the next address internally (sequential, branch, jump, register jump), redirects to the exception vector on external exceptions or misaligned targets, saves/restores the exception PC, and optionally predicts returns with a small return-address stack. Sits between the control unit / branch comparator and instruction memory.

## Interface
- WIDTH, 32, address width in bits (>= 8)
- RESET_ADDR, 32'h00003000, fetch address after reset
- EXC_ADDR, 32'h00004180, exception vector
- STEP, 4, sequential increment in bytes
- RAS_DEPTH, 4, return-address stack entries (power of 2, 2..16)

- CLK  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-low reset
- pcW  in  1  PC write enable; 0 = stall normal updates
- sel  in  2  next-PC source: 00 seq, 01 branch, 10 jump, 11 register
- branchTaken  in  1  branch condition, used only when sel=01
- branchOffset  in  WIDTH  sign-extended word offset
- jumpTarget  in  WIDTH  absolute jump target
- regTarget  in  WIDTH  register jump target
- exc  in  1  external exception request
- eret  in  1  return from exception
- call  in  1  push return address (sel=10/11 only)
- ret  in  1  pop return address (sel=11 only)
- currentAddress  out  WIDTH  current fetch address
- epc  out  WIDTH  saved exception PC
- excCause  out  2  last redirect cause: 0 none, 1 external, 2 misaligned
- rasEmpty  out  1  stack empty
- rasOverflow  out  1  sticky, set when a push overwrote the oldest entry
- rasUnderflow  out  1  combinational: ret requested with stack empty

## Operation
- seqAddr = currentAddress + STEP; branch target = seqAddr + (branchOffset << 2); all sums truncated to WIDTH (wrap modulo 2^WIDTH).
- Candidate target: sel=00 seqAddr; 01 branch target if branchTaken else seqAddr; 10 jumpTarget; 11 RAS top if ret and stack non-empty, else regTarget.
- Misaligned: candidate[1:0] != 0.
- Priority per edge, highest first:
  - Reset=0: currentAddress=RESET_ADDR, epc=0, excCause=0, stack emptied, rasOverflow=0.
  - exc=1 (ignores pcW): currentAddress=EXC_ADDR, epc=currentAddress, excCause=1.
  - eret=1 (ignores pcW): currentAddress=epc; excCause unchanged.
  - pcW=1 and misaligned: currentAddress=EXC_ADDR, epc=currentAddress, excCause=2; no stack change.
  - pcW=1: currentAddress=candidate; stack ops applied.
  - else hold all state.
- Stack ops only on a normal advance: push seqAddr if call; pop if ret and non-empty; both = replace top, count unchanged.
- Push when full: overwrite oldest (circular), count stays RAS_DEPTH, rasOverflow set.
- Pop when empty: no change; target falls back to regTarget.

## Timing
- Registered output; new address visible one cycle after the qualifying edge. Candidate/misalign/rasUnderflow combinational from current state and inputs.
- Reset values: currentAddress=RESET_ADDR, epc=0, excCause=0, rasEmpty=1, rasOverflow=0.
- Reset mid-stall or mid-exception wins unconditionally on that edge.
- exc and eret same cycle: exc wins, epc overwritten with currentAddress.

## Configuration
- RAS_EN defined: return-address stack as above.
- RAS_EN undefined: no stack storage; call/ret ignored; sel=11 always uses regTarget; rasEmpty=1, rasOverflow=0, rasUnderflow=0 constant.

## Test plan
- Reset low one edge, then pcW=1, sel=00 for 3 edges -> 0x3000, 0x3004, 0x3008, 0x300C; pcW=0 -> holds 0x300C.
- At 0x3010, sel=01, branchTaken=1, branchOffset=-2 -> 0x300C; branchTaken=0 -> 0x3014; currentAddress 0xFFFFFFFC, sel=00 -> wraps to 0x0.
- pcW=0, exc=1 at 0x3020 -> 0x4180, epc=0x3020, excCause=1; then eret -> 0x3020; exc+eret together -> exc wins.
- sel=10, jumpTarget=0x3002 -> 0x4180, excCause=2, epc=current, stack unchanged.
- RAS_EN, RAS_DEPTH=4: 5 calls from 0x3000,0x3100,...,0x3400 -> rasOverflow=1; 4 rets return 0x3404,0x3304,0x3204,0x3104; 5th ret -> rasUnderflow=1, goes to regTarget.
- call+ret same cycle at 0x3500 -> top becomes 0x3504, count unchanged; Reset low mid-sequence -> rasEmpty=1, currentAddress=0x3000.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter: fetch address, next-PC selection, exception redirect/return, optional return-address stack (RAS_EN).
// Latency: new address registered one cycle after the qualifying edge; candidate/misalign/rasUnderflow are combinational.
// Backpressure: pcW=0 stalls normal advance; exc/eret act regardless of pcW; synchronous active-low Reset wins over everything.
module pc_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_ADDR   = 32'h0000_4180,
    parameter int               STEP       = 4,
    parameter int               RAS_DEPTH  = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             pcW,
    input  logic [1:0]       sel,
    input  logic             branchTaken,
    input  logic [WIDTH-1:0] branchOffset,
    input  logic [WIDTH-1:0] jumpTarget,
    input  logic [WIDTH-1:0] regTarget,
    input  logic             exc,
    input  logic             eret,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] currentAddress,
    output logic [WIDTH-1:0] epc,
    output logic [1:0]       excCause,
    output logic             rasEmpty,
    output logic             rasOverflow,
    output logic             rasUnderflow
);

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_JMP = 2'b10;
    localparam logic [1:0] SEL_REG = 2'b11;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [1:0]       cause_q, cause_d;

    logic [WIDTH-1:0] seq_addr;
    logic [WIDTH-1:0] br_addr;
    logic [WIDTH-1:0] cand;
    logic             misaligned;
    logic             advance;
    logic             ras_empty;
    logic [WIDTH-1:0] ras_top;

    assign seq_addr = pc_q + WIDTH'(STEP);
    assign br_addr  = seq_addr + (branchOffset << 2);

    // Candidate next address from the selected source; a return only uses the stack when it holds something.
    always_comb begin
        cand = seq_addr;
        case (sel)
            SEL_SEQ: cand = seq_addr;
            SEL_BR:  cand = branchTaken ? br_addr : seq_addr;
            SEL_JMP: cand = jumpTarget;
            SEL_REG: cand = (ret && !ras_empty) ? ras_top : regTarget;
            default: cand = seq_addr;
        endcase
    end

    assign misaligned = (cand[1:0] != 2'b00);
    // Only a clean, enabled, aligned advance is allowed to touch the return stack.
    assign advance    = Reset && !exc && !eret && pcW && !misaligned;

    // Next-state for PC, EPC and cause, highest-priority event first.
    always_comb begin
        pc_d    = pc_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        if (exc) begin
            pc_d    = EXC_ADDR;
            epc_d   = pc_q;
            cause_d = 2'd1;
        end else if (eret) begin
            pc_d    = epc_q;
        end else if (pcW && misaligned) begin
            pc_d    = EXC_ADDR;
            epc_d   = pc_q;
            cause_d = 2'd2;
        end else if (pcW) begin
            pc_d    = cand;
        end
    end

    // PC state registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            pc_q    <= RESET_ADDR;
            epc_q   <= '0;
            cause_q <= 2'd0;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    assign currentAddress = pc_q;
    assign epc            = epc_q;
    assign excCause       = cause_q;

`ifdef RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    // Circular stack: top_q points at the newest entry, so pushing past
    // capacity naturally overwrites the oldest one.
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]    top_q;
    logic [PW:0]      cnt_q;
    logic             ovf_q;
    logic             do_push;
    logic             do_pop;
    logic [PW-1:0]    top_inc;

    assign ras_empty = (cnt_q == '0);
    assign ras_top   = ras_q[top_q];
    assign top_inc   = top_q + 1'b1;
    assign do_push   = advance && call && sel[1];
    assign do_pop    = advance && ret && (sel == SEL_REG) && !ras_empty;

    // Stack pointer, count and sticky overflow; call+ret together replaces the top in place.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            top_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (do_push && do_pop) begin
            ras_q[top_q] <= seq_addr;
        end else if (do_push) begin
            top_q          <= top_inc;
            ras_q[top_inc] <= seq_addr;
            if (cnt_q == (PW+1)'(RAS_DEPTH)) begin
                ovf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (do_pop) begin
            top_q <= top_q - 1'b1;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign rasEmpty     = ras_empty;
    assign rasOverflow  = ovf_q;
    assign rasUnderflow = ret && ras_empty;
`else
    logic unused_ras;

    assign ras_empty    = 1'b1;
    assign ras_top      = '0;
    assign unused_ras   = call ^ ret ^ advance;
    assign rasEmpty     = 1'b1;
    assign rasOverflow  = 1'b0;
    assign rasUnderflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        pcW;
    logic [1:0]  sel;
    logic        branchTaken;
    logic [31:0] branchOffset;
    logic [31:0] jumpTarget;
    logic [31:0] regTarget;
    logic        exc;
    logic        eret;
    logic        call;
    logic        ret;
    logic [31:0] currentAddress;
    logic [31:0] epc;
    logic [1:0]  excCause;
    logic        rasEmpty;
    logic        rasOverflow;
    logic        rasUnderflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] epc;
        logic [1:0]  cause;
        logic        empty;
        logic        ovf;
        string       name;
    } exp_t;

    exp_t sb[$];

    pc_unit dut (
        .CLK(CLK), .Reset(Reset), .pcW(pcW), .sel(sel),
        .branchTaken(branchTaken), .branchOffset(branchOffset),
        .jumpTarget(jumpTarget), .regTarget(regTarget),
        .exc(exc), .eret(eret), .call(call), .ret(ret),
        .currentAddress(currentAddress), .epc(epc), .excCause(excCause),
        .rasEmpty(rasEmpty), .rasOverflow(rasOverflow), .rasUnderflow(rasUnderflow)
    );

    always #5 CLK = ~CLK;

    // Monitor: state is presented every cycle; compare on the falling edge.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (currentAddress !== e.addr) begin
                failures++;
                $display("FAIL %s addr got=%h exp=%h", e.name, currentAddress, e.addr);
            end
            checks++;
            if (epc !== e.epc) begin
                failures++;
                $display("FAIL %s epc got=%h exp=%h", e.name, epc, e.epc);
            end
            checks++;
            if (excCause !== e.cause) begin
                failures++;
                $display("FAIL %s cause got=%0d exp=%0d", e.name, excCause, e.cause);
            end
            checks++;
            if (rasEmpty !== e.empty) begin
                failures++;
                $display("FAIL %s rasEmpty got=%b exp=%b", e.name, rasEmpty, e.empty);
            end
            checks++;
            if (rasOverflow !== e.ovf) begin
                failures++;
                $display("FAIL %s rasOverflow got=%b exp=%b", e.name, rasOverflow, e.ovf);
            end
        end
    end

    // Clock one edge with the current inputs and queue the expected post-edge state.
    task automatic step(input logic [31:0] a, input logic [31:0] ep, input logic [1:0] c,
                        input logic emp, input logic ov, input string nm);
        exp_t e;
        @(posedge CLK);
        #1;
        e.addr = a; e.epc = ep; e.cause = c; e.empty = emp; e.ovf = ov; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic chk_uf(input logic exp_uf, input string nm);
        #1;
        checks++;
        if (rasUnderflow !== exp_uf) begin
            failures++;
            $display("FAIL %s rasUnderflow got=%b exp=%b", nm, rasUnderflow, exp_uf);
        end
    endtask

    task automatic idle();
        pcW = 0; sel = 2'b00; branchTaken = 0; branchOffset = 0;
        jumpTarget = 0; regTarget = 0; exc = 0; eret = 0; call = 0; ret = 0;
    endtask

    initial begin
        idle();
        Reset = 0;
        pcW = 1; exc = 1;
        step(32'h3000, 0, 0, 1, 0, "reset");
        Reset = 1; exc = 0;

        // Sequential, stall, branch
        pcW = 1; sel = 2'b00;
        step(32'h3004, 0, 0, 1, 0, "seq1");
        step(32'h3008, 0, 0, 1, 0, "seq2");
        step(32'h300C, 0, 0, 1, 0, "seq3");
        pcW = 0;
        step(32'h300C, 0, 0, 1, 0, "stall");
        pcW = 1;
        step(32'h3010, 0, 0, 1, 0, "seq4");
        sel = 2'b01; branchTaken = 1; branchOffset = 32'hFFFF_FFFE;
        step(32'h300C, 0, 0, 1, 0, "br_taken");
        branchTaken = 0;
        step(32'h3010, 0, 0, 1, 0, "br_not_taken");

        // Wrap-around
        sel = 2'b10; jumpTarget = 32'hFFFF_FFFC;
        step(32'hFFFF_FFFC, 0, 0, 1, 0, "jump_top");
        sel = 2'b00;
        step(32'h0000_0000, 0, 0, 1, 0, "wrap");
        sel = 2'b10; jumpTarget = 32'h3020;
        step(32'h3020, 0, 0, 1, 0, "jump_3020");

        // Exceptions
        pcW = 0; exc = 1;
        step(32'h4180, 32'h3020, 1, 1, 0, "exc");
        exc = 0; eret = 1;
        step(32'h3020, 32'h3020, 1, 1, 0, "eret");
        eret = 0; pcW = 1; sel = 2'b00;
        step(32'h3024, 32'h3020, 1, 1, 0, "seq5");
        pcW = 0; exc = 1; eret = 1;
        step(32'h4180, 32'h3024, 1, 1, 0, "exc_eret");
        exc = 0;
        step(32'h3024, 32'h3024, 1, 1, 0, "eret2");
        eret = 0;

        // Misaligned jump, with call asserted: stack must stay untouched
        pcW = 1; sel = 2'b10; jumpTarget = 32'h3002; call = 1;
        step(32'h4180, 32'h3024, 2, 1, 0, "misalign");
        pcW = 0;
        step(32'h4180, 32'h3024, 2, 1, 0, "misalign_stall");
        call = 0; pcW = 1; jumpTarget = 32'h3000;
        step(32'h3000, 32'h3024, 2, 1, 0, "jump_3000");

`ifdef RAS_EN
        // Five calls into a 4-deep stack
        call = 1;
        for (int i = 1; i <= 5; i++) begin
            jumpTarget = 32'h3000 + 32'(i) * 32'h100;
            step(jumpTarget, 32'h3024, 2, 0, (i == 5), "call");
        end
        call = 0; sel = 2'b11; ret = 1; regTarget = 32'h3800;
        step(32'h3404, 32'h3024, 2, 0, 1, "ret1");
        step(32'h3304, 32'h3024, 2, 0, 1, "ret2");
        step(32'h3204, 32'h3024, 2, 0, 1, "ret3");
        chk_uf(1'b0, "uf_before_last");
        step(32'h3104, 32'h3024, 2, 1, 1, "ret4");
        chk_uf(1'b1, "uf_empty");
        step(32'h3800, 32'h3024, 2, 1, 1, "ret5_fallback");

        // call+ret together replaces the top entry
        ret = 0; call = 1; sel = 2'b10; jumpTarget = 32'h3500;
        step(32'h3500, 32'h3024, 2, 0, 1, "call_3500");
        sel = 2'b11; ret = 1; regTarget = 32'h3900;
        step(32'h3804, 32'h3024, 2, 0, 1, "call_ret");
        call = 0;
        step(32'h3504, 32'h3024, 2, 1, 1, "ret_replaced");
        ret = 0; call = 1; sel = 2'b10; jumpTarget = 32'h3600;
        step(32'h3600, 32'h3024, 2, 0, 1, "call_3600");
`else
        // Without the stack, register jumps ignore ret/call
        sel = 2'b11; ret = 1; call = 1; regTarget = 32'h3200;
        chk_uf(1'b0, "uf_disabled");
        step(32'h3200, 32'h3024, 2, 1, 0, "regjump");
        sel = 2'b10; jumpTarget = 32'h3600;
        step(32'h3600, 32'h3024, 2, 1, 0, "jump_3600");
`endif

        // Reset wins over exc and pcW mid-sequence
        Reset = 0; exc = 1; pcW = 1;
        step(32'h3000, 0, 0, 1, 0, "reset_mid");
        idle();
        Reset = 1;

        repeat (2) @(negedge CLK);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
